// File: rtl/ascon_permutation_ctrl_if.sv
// Handshake and control bundle between the ASCON top-level FSM/datapath and the
// permutation round sequencer.
//   start_i  : permutation request (taken only while ready_o=1)
//   mode_i   : 0 = p^a round count, 1 = p^b round count
//   round_o  : round index for constant addition
//   select_o : datapath input mux, 1 = external state, 0 = feedback
//   en_reg_o : state-register load enable
//   ready_o  : sequencer can take a start
//   busy_o   : permutation in progress
//   done_o   : one-cycle pulse, final round result is in the state register
// The master modport is the requester/datapath side; the slave modport is the sequencer.
interface ascon_permutation_ctrl_if;
   logic       start_i;
   logic       mode_i;
   logic [3:0] round_o;
   logic       select_o;
   logic       en_reg_o;
   logic       ready_o;
   logic       busy_o;
   logic       done_o;

   modport master (
      output start_i, mode_i,
      input  round_o, select_o, en_reg_o, ready_o, busy_o, done_o
   );

   modport slave (
      input  start_i, mode_i,
      output round_o, select_o, en_reg_o, ready_o, busy_o, done_o
   );
endinterface

// File: rtl/ascon_permutation_ctrl.sv
// ASCON permutation round sequencer. Steps the round index from 12-N up to 11,
// drives the datapath input-mux select and state-register enable, and pulses
// done once the last round has been written back.
// Ports:
//   clock_i : system clock, rising edge
//   reset_i : synchronous active-high reset
//   bus     : ascon_permutation_ctrl_if.slave (start/mode in, round/select/enable/status out)
//
// state | meaning
// IDLE  | waiting for start; round_o shows last count (0 after reset)
// RUN   | one permutation round per cycle, state register loading
// DONE  | done_o pulse; a start here goes straight back to RUN
module ascon_permutation_ctrl #(
   parameter int NB_ROUNDS_A = 12,
   parameter int NB_ROUNDS_B = 6
) (
   input logic                      clock_i,
   input logic                      reset_i,
   ascon_permutation_ctrl_if.slave  bus
);

   localparam logic [3:0] FIRST_RND_A = 4'(12 - NB_ROUNDS_A);
   localparam logic [3:0] FIRST_RND_B = 4'(12 - NB_ROUNDS_B);
   localparam logic [3:0] LAST_RND    = 4'd11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_first;
   logic       w_first_nxt;
   logic [3:0] w_first_rnd;

   assign w_first_rnd = bus.mode_i ? FIRST_RND_B : FIRST_RND_A;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_first <= w_first_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_first_nxt = r_first;
      case (r_state)
         IDLE, DONE: begin
            // mode_i only matters on the accepting edge; it is latched via the start count
            if (bus.start_i) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = w_first_rnd;
               w_first_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            w_first_nxt = 1'b0;
            if (r_cnt == LAST_RND) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Moore outputs: decoded only from registered state, count and first flag
   assign bus.round_o  = r_cnt;
   assign bus.select_o = (r_state == RUN) && r_first;
   assign bus.en_reg_o = (r_state == RUN);
   assign bus.busy_o   = (r_state == RUN);
   assign bus.done_o   = (r_state == DONE);
   assign bus.ready_o  = (r_state == IDLE) || (r_state == DONE);

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
module tb_ascon_permutation_ctrl;

   logic clk;
   logic rst;

   ascon_permutation_ctrl_if bus_if ();

   ascon_permutation_ctrl #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed vector: {round[3:0], select, en_reg, done, busy, ready}
   typedef struct packed {
      logic [8:0] vec;
      logic [7:0] rc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // ASCON round constants, written out by hand
   logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                               8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

   localparam logic [8:0] IDLE_RST = {4'd0,  5'b00001};
   localparam logic [8:0] IDLE_END = {4'd11, 5'b00001};

   function automatic logic [8:0] observe();
      return {bus_if.round_o, bus_if.select_o, bus_if.en_reg_o,
              bus_if.done_o, bus_if.busy_o, bus_if.ready_o};
   endfunction

   // Constant that constant_addition derives from the round index
   function automatic logic [7:0] rc_of(input logic [3:0] r);
      logic [3:0] hi;
      hi = 4'hf - r;
      return {hi, r};
   endfunction

   // Push the expected RUN cycles of one permutation (optionally cut at last_r)
   // and, when complete, its DONE cycle.
   task automatic push_perm(input logic mode, input int last_r);
      int first;
      exp_t e;
      first = mode ? 6 : 0;
      for (int r = first; r <= last_r; r++) begin
         e.vec = {4'(r), (r == first), 1'b1, 1'b0, 1'b1, 1'b0};
         e.rc  = rc_tab[r];
         sb.push_back(e);
      end
      if (last_r == 11) begin
         e.vec = {4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
         e.rc  = 8'h00;
         sb.push_back(e);
      end
   endtask

   // Monitor: any cycle with en_reg_o or done_o is a DUT output event
   always @(negedge clk) begin
      logic [8:0] act;
      exp_t e;
      act = observe();
      if (bus_if.en_reg_o || bus_if.done_o) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event t=%0t actual=%b required=none", $time, act);
         end else begin
            e = sb.pop_front();
            if (act !== e.vec) begin
               failures++;
               $display("FAIL event t=%0t actual=%b required=%b", $time, act, e.vec);
            end
            if (bus_if.en_reg_o) begin
               checks++;
               if (rc_of(bus_if.round_o) !== e.rc) begin
                  failures++;
                  $display("FAIL round_const t=%0t actual=%h required=%h",
                           $time, rc_of(bus_if.round_o), e.rc);
               end
            end
         end
      end
   end

   task automatic check_vec(input string name, input logic [8:0] req);
      logic [8:0] act;
      act = observe();
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout actual=%0d_pending required=0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic run_one(input logic mode, input string name);
      @(negedge clk);
      bus_if.start_i = 1'b1;
      bus_if.mode_i  = mode;
      push_perm(mode, 11);
      @(negedge clk);
      bus_if.start_i = 1'b0;
      drain(name);
      @(negedge clk);
      check_vec({name, "_idle"}, IDLE_END);
   endtask

   initial begin
      rst            = 1'b1;
      bus_if.start_i = 1'b0;
      bus_if.mode_i  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_vec("reset_idle", IDLE_RST);
      end

      run_one(1'b0, "pa");
      run_one(1'b1, "pb");

      // start held high with mode 1: three back-to-back permutations, 7 cycles each
      @(negedge clk);
      bus_if.start_i = 1'b1;
      bus_if.mode_i  = 1'b1;
      for (int k = 0; k < 3; k++) push_perm(1'b1, 11);
      repeat (21) @(negedge clk);
      bus_if.start_i = 1'b0;
      drain("b2b");
      @(negedge clk);
      check_vec("b2b_idle", IDLE_END);

      // mode toggling and a stray start during RUN must not disturb the sequence
      @(negedge clk);
      bus_if.start_i = 1'b1;
      bus_if.mode_i  = 1'b0;
      push_perm(1'b0, 11);
      @(negedge clk);
      bus_if.start_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus_if.mode_i  = ~bus_if.mode_i;
         bus_if.start_i = (i == 4);
         @(negedge clk);
      end
      bus_if.start_i = 1'b0;
      bus_if.mode_i  = 1'b0;
      drain("toggle");
      @(negedge clk);
      check_vec("toggle_idle", IDLE_END);

      // reset while round 4 of p^a is showing
      @(negedge clk);
      bus_if.start_i = 1'b1;
      bus_if.mode_i  = 1'b0;
      push_perm(1'b0, 4);
      @(negedge clk);
      bus_if.start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_vec("mid_reset", IDLE_RST);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_vec("post_reset_idle", IDLE_RST);
      drain("mid_reset_events");

      // reset and start together: reset wins
      bus_if.start_i = 1'b1;
      rst            = 1'b1;
      @(negedge clk);
      check_vec("reset_wins", IDLE_RST);
      rst            = 1'b0;
      bus_if.start_i = 1'b0;

      run_one(1'b0, "pa_after_reset");

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL leftover actual=%0d required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ascon_permutation_ctrl.md
# ascon_permutation_ctrl

Sequencer for the ASCON permutation datapath: constant addition, then substitution layer, then linear diffusion, with a state register closing the loop. The block accepts a start request with a round-count mode (p^a = 12 rounds, p^b = 6 rounds). Each cycle it drives the round index consumed by constant addition, the input-mux select and the state-register enable, then signals completion. It sits between the top-level ASCON FSM and the permutation datapath.

## Interface
- NB_ROUNDS_A, 12, round count for mode 0 (p^a); legal range 1..12
- NB_ROUNDS_B, 6, round count for mode 1 (p^b); legal range 1..NB_ROUNDS_A
- clock_i  in  1  system clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  permutation request, sampled only while ready_o=1
- mode_i  in  1  0 = NB_ROUNDS_A rounds, 1 = NB_ROUNDS_B rounds; sampled with an accepted start
- round_o  out  4  round index to constant_addition
- select_o  out  1  datapath input mux: 1 = external state, 0 = state-register feedback
- en_reg_o  out  1  state-register load enable
- ready_o  out  1  controller can accept start_i
- busy_o  out  1  permutation in progress
- done_o  out  1  one-cycle pulse: the final round result is in the state register

## Operation
- One clock; reset is synchronous and active-high.
- FSM states:
  - IDLE (reset state)
  - RUN
  - DONE
  - Unused encodings go to IDLE on the next edge.
- Internal 4-bit round counter `cnt` and 1-bit `first` flag.
- First round index: `first_rnd = 12 - N`, where N is the round count selected by mode_i. With defaults, mode 0 starts at 0 and mode 1 starts at 6. The last round is always 11, per the ASCON constant table.
- An accepted start is start_i=1 while in IDLE or DONE. On acceptance:
  - cnt <= first_rnd
  - first <= 1
  - state -> RUN
- RUN, every cycle:
  - en_reg_o=1
  - round_o=cnt
  - select_o=first
  - first <= 0
- RUN, round advance:
  - If cnt < 11: cnt <= cnt+1.
  - If cnt == 11: state -> DONE. cnt holds at 11; no wrap.
- DONE:
  - done_o=1, en_reg_o=0.
  - Next state is RUN if start_i=1, otherwise IDLE. This allows back-to-back permutations with no gap.
- IDLE:
  - en_reg_o=0, select_o=0.
  - round_o shows cnt: 0 after reset, otherwise the last value, 11.
- start_i while busy_o=1 is ignored. mode_i changes during RUN have no effect.
- Derived outputs:
  - ready_o = (IDLE or DONE)
  - busy_o = RUN

## Timing
- All outputs are decoded from registered state/cnt/first (Moore). There is no combinational path from start_i or mode_i to any output.
- Reset values:
  - state=IDLE, cnt=0, first=0
  - round_o=0, select_o=0, en_reg_o=0, ready_o=1, busy_o=0, done_o=0
- Start accepted at edge E:
  - RUN occupies cycles E+1 .. E+N.
  - select_o=1 only in cycle E+1.
  - done_o=1 in cycle E+N+1.
  - Latency from start to done is N+1 cycles: 13 for p^a, 7 for p^b.
- en_reg_o is high for exactly N consecutive cycles per permutation.
- Back-to-back: start_i=1 during DONE gives RUN in the next cycle with select_o=1. Throughput is one permutation per N+1 cycles.
- reset_i=1 mid-RUN: the next edge forces all reset values. No done_o pulse is produced and en_reg_o drops the same edge.
- reset_i and start_i both high: reset wins.

## Test plan
- Reset, then hold idle -> round_o=0, ready_o=1, busy_o=0, en_reg_o=0, done_o=0 for 5 cycles.
- start_i=1, mode_i=0 for one cycle:
  - round_o steps 0,1,...,11 over 12 cycles with en_reg_o=1.
  - select_o=1 only on round 0.
  - done_o pulses in the 13th cycle, then IDLE.
- start_i=1, mode_i=1:
  - round_o steps 6..11 over 6 cycles; select_o=1 on round 6.
  - done_o in the 7th cycle.
  - On round 6, the datapath constant addition applies constant 0x96 to word 2 of the state.
- start_i held high with mode_i=1 continuously:
  - Permutations repeat every 7 cycles.
  - start_i is ignored during RUN.
  - Every RUN begins with select_o=1 and round_o=6.
- mode_i toggled during RUN -> the round sequence is unchanged.
- Reset mid-permutation:
  - reset_i asserted at round 4 (mode 0) -> next cycle round_o=0, en_reg_o=0, no done_o.
  - A following start runs a full 12 rounds.
